// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Load/store memory responder with valid/ready request and
//            response handshakes and a programmable access latency.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  LAT        = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic [31:0] mem_q [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic          w_cm_we;
    logic [31:0]   w_cm_addr;
    logic [31:0]   w_cm_wdata;
    logic [3:0]    w_cm_be;
    logic          w_cm_err;
    logic [AW-1:0] w_cm_idx;

    assign w_accept = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign w_commit = (state_d == ST_RESP) && (state_q != ST_RESP);

    // With zero latency the commit happens on the accept edge itself, so the
    // live request fields are used instead of the not-yet-captured copies.
    assign w_cm_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign w_cm_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign w_cm_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign w_cm_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign w_cm_err   = (w_cm_addr[1:0] != 2'b00) || (w_cm_addr >= ADDR_LIMIT);
    assign w_cm_idx   = w_cm_addr[AW+1:2];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (w_accept) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    req_ready_d = 1'b0;
                    if (LAT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = w_cm_err;
            resp_rdata_d = (!w_cm_we && !w_cm_err) ? mem_q[w_cm_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    // Array is not reset; while rst is low the FSM sits in IDLE with
    // req_ready low, so no commit (and hence no write) can occur.
    always_ff @(posedge clk) begin
        if (w_commit && w_cm_we && !w_cm_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_cm_be[b]) begin
                    mem_q[w_cm_idx][8*b +: 8] <= w_cm_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Scoreboard bench for data_mem_responder at latencies 2, 4 and 0.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam int N       = 3;
    localparam int TIMEOUT = 50;
    localparam int D_L2    = 0;
    localparam int D_L4    = 1;
    localparam int D_L0    = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_we     [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic [3:0]  req_be     [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];
    logic        busy       [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat_of [N] = '{2, 4, 0};

    logic [31:0] model [N][256];
    exp_t        sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .busy(busy[2])
    );

    // Drives one request (called at a negedge, returns at a negedge) and, if
    // tracked, pushes the reference model's expected response.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input bit track, output int acc);
        exp_t e;
        logic [7:0] idx;
        acc = -1;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (req_ready[d] === 1'b1) begin
                @(posedge clk);
                acc = 0;
                break;
            end
            @(negedge clk);
        end
        if (acc == 0) @(negedge clk);
        req_valid[d] = 1'b0;
        checks++;
        if (acc < 0) begin
            failures++;
            $display("FAIL accept_timeout: inst %0d addr %h not accepted, required within %0d cycles", d, addr, TIMEOUT);
            return;
        end
        acc = cyc;
        if (track) begin
            idx     = addr[9:2];
            e.err   = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
            e.rdata = (!we && !e.err) ? model[d][idx] : 32'd0;
            sb.push_back(e);
            if (we && !e.err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    task automatic wait_resp(input int d, output int seen);
        seen = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (resp_valid[d] === 1'b1) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (seen < 0) begin
            failures++;
            $display("FAIL resp_timeout: inst %0d resp_valid never rose, required within %0d cycles", d, TIMEOUT);
        end
    endtask

    task automatic take_resp(input int d);
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_hold: inst %0d ready/valid/busy=%b%b%b required 000",
                             d, req_ready[d], resp_valid[d], busy[d]);
                end
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: got %b required 0", req_ready[0]);
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_release: inst %0d got %b required 1", d, req_ready[d]);
            end
        end
    endtask

    // Issues a tracked request, checks latency if asked, pops and compares.
    task automatic test_store_load;
        int acc, seen;
        exp_t e;
        logic [31:0] a [4] = '{32'h10, 32'h10, 32'h10, 32'h10};
        logic        w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] v [4] = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'h0};
        logic [3:0]  m [4] = '{4'hF, 4'h0, 4'b0101, 4'h0};
        logic [31:0] lit [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDE22BE44};
        for (int t = 0; t < 4; t++) begin
            issue(D_L2, w[t], a[t], v[t], m[t], 1'b1, acc);
            wait_resp(D_L2, seen);
            checks++;
            if (seen - acc !== 2) begin
                failures++;
                $display("FAIL latency_l2[%0d]: got %0d cycles required 2", t, seen - acc);
            end
            e = sb.pop_front();
            checks++;
            if (resp_rdata[D_L2] !== e.rdata || resp_err[D_L2] !== e.err) begin
                failures++;
                $display("FAIL store_load[%0d]: got rdata=%h err=%b required rdata=%h err=%b",
                         t, resp_rdata[D_L2], resp_err[D_L2], e.rdata, e.err);
            end
            checks++;
            if (resp_rdata[D_L2] !== lit[t]) begin
                failures++;
                $display("FAIL store_load_lit[%0d]: got %h required %h", t, resp_rdata[D_L2], lit[t]);
            end
            take_resp(D_L2);
        end
    endtask

    task automatic test_backpressure;
        int acc, seen;
        exp_t e;
        logic [31:0] held;
        issue(D_L2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
        wait_resp(D_L2, seen);
        held = resp_rdata[D_L2];
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                req_valid[D_L2] = 1'b1;
                req_we[D_L2]    = 1'b1;
                req_addr[D_L2]  = 32'h10;
                req_wdata[D_L2] = 32'h0;
                req_be[D_L2]    = 4'hF;
            end
            @(negedge clk);
            req_valid[D_L2] = 1'b0;
            checks++;
            if (resp_valid[D_L2] !== 1'b1 || resp_rdata[D_L2] !== held || req_ready[D_L2] !== 1'b0) begin
                failures++;
                $display("FAIL stall_stable[%0d]: valid=%b rdata=%h ready=%b required 1 %h 0",
                         c, resp_valid[D_L2], resp_rdata[D_L2], req_ready[D_L2], held);
            end
        end
        e = sb.pop_front();
        checks++;
        if (held !== e.rdata || resp_err[D_L2] !== e.err) begin
            failures++;
            $display("FAIL stall_data: got %h/%b required %h/%b", held, resp_err[D_L2], e.rdata, e.err);
        end
        take_resp(D_L2);
        checks++;
        if (busy[D_L2] !== 1'b0 || resp_valid[D_L2] !== 1'b0 || req_ready[D_L2] !== 1'b1
            || resp_rdata[D_L2] !== 32'd0) begin
            failures++;
            $display("FAIL resp_release: busy=%b valid=%b ready=%b rdata=%h required 0 0 1 0",
                     busy[D_L2], resp_valid[D_L2], req_ready[D_L2], resp_rdata[D_L2]);
        end
        // The pulsed store was ignored, so the word keeps its prior value.
        issue(D_L2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
        wait_resp(D_L2, seen);
        e = sb.pop_front();
        checks++;
        if (resp_rdata[D_L2] !== e.rdata || resp_rdata[D_L2] !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL ignored_req: got %h required %h", resp_rdata[D_L2], e.rdata);
        end
        take_resp(D_L2);
    endtask

    task automatic test_errors;
        int acc, seen;
        exp_t e;
        logic [31:0] a [3] = '{32'h13, 32'h10, 32'h400};
        logic        w [3] = '{1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            issue(D_L2, w[t], a[t], 32'hFFFFFFFF, 4'hF, 1'b1, acc);
            wait_resp(D_L2, seen);
            checks++;
            if (seen - acc !== 2) begin
                failures++;
                $display("FAIL err_latency[%0d]: got %0d required 2", t, seen - acc);
            end
            e = sb.pop_front();
            checks++;
            if (resp_rdata[D_L2] !== e.rdata || resp_err[D_L2] !== e.err) begin
                failures++;
                $display("FAIL err_resp[%0d]: got rdata=%h err=%b required rdata=%h err=%b",
                         t, resp_rdata[D_L2], resp_err[D_L2], e.rdata, e.err);
            end
            take_resp(D_L2);
        end
    endtask

    task automatic test_reset_abort;
        int acc, seen;
        exp_t e;
        issue(D_L4, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, acc);
        wait_resp(D_L4, seen);
        checks++;
        if (seen - acc !== 4) begin
            failures++;
            $display("FAIL latency_l4: got %0d required 4", seen - acc);
        end
        void'(sb.pop_front());
        take_resp(D_L4);
        issue(D_L4, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, acc);
        @(negedge clk);
        checks++;
        if (busy[D_L4] !== 1'b1 || resp_valid[D_L4] !== 1'b0) begin
            failures++;
            $display("FAIL in_wait: busy=%b valid=%b required 1 0", busy[D_L4], resp_valid[D_L4]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy[D_L4] !== 1'b0 || req_ready[D_L4] !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: busy=%b ready=%b required 0 0", busy[D_L4], req_ready[D_L4]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (resp_valid[D_L4] !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_resp: got valid=%b required 0", resp_valid[D_L4]);
        end
        issue(D_L4, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc);
        wait_resp(D_L4, seen);
        e = sb.pop_front();
        checks++;
        if (resp_rdata[D_L4] !== e.rdata || resp_rdata[D_L4] !== 32'h12345678) begin
            failures++;
            $display("FAIL abort_no_write: got %h required %h", resp_rdata[D_L4], e.rdata);
        end
        take_resp(D_L4);
    endtask

    task automatic test_zero_latency;
        int acc, seen;
        exp_t e;
        logic        w [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            issue(D_L0, w[t], 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, acc);
            wait_resp(D_L0, seen);
            checks++;
            if (seen - acc !== 0) begin
                failures++;
                $display("FAIL latency_l0[%0d]: got %0d extra cycles required 0", t, seen - acc);
            end
            e = sb.pop_front();
            checks++;
            if (resp_rdata[D_L0] !== e.rdata || resp_err[D_L0] !== e.err) begin
                failures++;
                $display("FAIL l0_resp[%0d]: got %h/%b required %h/%b",
                         t, resp_rdata[D_L0], resp_err[D_L0], e.rdata, e.err);
            end
            take_resp(D_L0);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            req_be[d]     = 4'd0;
            resp_ready[d] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_backpressure();
        test_errors();
        test_reset_abort();
        test_zero_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
